// File: rtl/histogram_frame_sequencer.sv
// Per-frame controller for the 256-bin gray histogram: clears the bin RAM, accumulates pixels with
// read-modify-write forwarding, then sweeps the bins into a cumulative RAM and publishes thresholds.
module histogram_frame_sequencer #(
  parameter int BIN_W = 20,
  parameter int NBINS = 256
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iFval,
  input  logic             iGrayValid,
  input  logic [7:0]       iGray,
  output logic [7:0]       oRdAddr,
  input  logic [BIN_W-1:0] iRdData,
  output logic             oWrEn,
  output logic [7:0]       oWrAddr,
  output logic [BIN_W-1:0] oWrData,
  output logic             oCumWrEn,
  output logic [7:0]       oCumWrAddr,
  output logic [BIN_W-1:0] oCumWrData,
  output logic [7:0]       oThresh25,
  output logic [7:0]       oThresh50,
  output logic [7:0]       oThresh75,
  output logic [BIN_W-1:0] oMaxValue,
  output logic [BIN_W-1:0] oPixCount,
  output logic             oBusy,
  output logic             oDone,
  output logic             oSkip
);

  typedef enum logic [2:0] {INIT_CLR, WAIT_SOF, ACCUM, FLUSH, CUMSUM} state_t;

  localparam logic [8:0] LAST_BIN = 9'(NBINS - 1);
  localparam logic [8:0] SWEEP_END = 9'(NBINS);

  function automatic logic [BIN_W-1:0] sat_inc(input logic [BIN_W-1:0] x);
    return (x == '1) ? x : x + BIN_W'(1);
  endfunction

  function automatic logic [BIN_W-1:0] sat_add(input logic [BIN_W-1:0] a, input logic [BIN_W-1:0] b);
    logic [BIN_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[BIN_W] ? '1 : s[BIN_W-1:0];
  endfunction

  function automatic logic [7:0] pick_thresh(input logic found, input logic [7:0] th, input logic empty);
    return (empty || !found) ? 8'hFF : th;
  endfunction

  state_t           state, state_nx;
  logic [8:0]       cnt;
  logic [7:0]       cnt_lo_m1;
  logic             fval_q, rise, fall, pix_ok, cum_step, publish;
  logic             vld_p0;
  logic [7:0]       bin_p0;
  logic             wr_en_p1, wr_en_p2;
  logic [7:0]       wr_addr_p1, wr_addr_p2;
  logic [BIN_W-1:0] wr_data_p1, wr_data_p2, fwd_p0;
  logic [BIN_W-1:0] pix_cnt, cum, cum_nx, max_sh, max_nx, t25, t50, t75;
  logic             f25, f50, f75;
  logic [7:0]       th25_sh, th50_sh, th75_sh;

  always_comb begin
    rise      = iFval & ~fval_q;
    fall      = ~iFval & fval_q;
    pix_ok    = (state == ACCUM) && iFval && iGrayValid;
    cum_step  = (state == CUMSUM) && (cnt != 9'd0);
    publish   = (state == CUMSUM) && (cnt == SWEEP_END);
    cnt_lo_m1 = cnt[7:0] - 8'd1;
    // RAM data is stale when the same bin was written last cycle or is being written now
    fwd_p0 = iRdData;
    if (wr_en_p1 && wr_addr_p1 == bin_p0)
      fwd_p0 = wr_data_p1;
    else if (wr_en_p2 && wr_addr_p2 == bin_p0)
      fwd_p0 = wr_data_p2;
    cum_nx = sat_add(cum, iRdData);
    max_nx = (iRdData > max_sh) ? iRdData : max_sh;
    t25    = pix_cnt >> 2;
    t50    = pix_cnt >> 1;
    t75    = t50 + t25;
  end

  assign oRdAddr    = (state == ACCUM) ? iGray : cnt[7:0];
  assign oWrEn      = wr_en_p1;
  assign oWrAddr    = wr_addr_p1;
  assign oWrData    = wr_data_p1;
  assign oCumWrEn   = cum_step;
  assign oCumWrAddr = cnt_lo_m1;
  assign oCumWrData = cum_nx;
  assign oBusy      = (state != WAIT_SOF);
  assign oSkip      = rise && (state == INIT_CLR || state == FLUSH || state == CUMSUM);

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) state <= INIT_CLR;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      INIT_CLR: if (cnt == LAST_BIN) state_nx = WAIT_SOF;
      WAIT_SOF: if (rise) state_nx = ACCUM;
      ACCUM:    if (fall) state_nx = FLUSH;
      FLUSH:    if (cnt == 9'd1) state_nx = CUMSUM;
      CUMSUM:   if (cnt == SWEEP_END) state_nx = WAIT_SOF;
      default:  state_nx = INIT_CLR;
    endcase
  end

  // p0: read issued; p1: write port; p2: write retired last cycle
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      cnt       <= '0;
      fval_q    <= 1'b0;
      vld_p0    <= 1'b0;
      wr_en_p1  <= 1'b0;
      wr_en_p2  <= 1'b0;
      f25       <= 1'b0;
      f50       <= 1'b0;
      f75       <= 1'b0;
      oDone     <= 1'b0;
      oThresh25 <= '0;
      oThresh50 <= '0;
      oThresh75 <= '0;
      oMaxValue <= '0;
      oPixCount <= '0;
    end else begin
      cnt      <= (state_nx != state) ? 9'd0 : cnt + 9'd1;
      fval_q   <= iFval;
      vld_p0   <= pix_ok;
      wr_en_p1 <= (state == INIT_CLR) || cum_step || vld_p0;
      wr_en_p2 <= wr_en_p1;
      oDone    <= publish;
      if (state == FLUSH) begin
        f25 <= 1'b0;
        f50 <= 1'b0;
        f75 <= 1'b0;
      end else if (cum_step) begin
        if (cum_nx >= t25) f25 <= 1'b1;
        if (cum_nx >= t50) f50 <= 1'b1;
        if (cum_nx >= t75) f75 <= 1'b1;
      end
      if (publish) begin
        oThresh25 <= pick_thresh(f25, th25_sh, pix_cnt == '0);
        oThresh50 <= pick_thresh(f50, th50_sh, pix_cnt == '0);
        oThresh75 <= pick_thresh(f75, th75_sh, pix_cnt == '0);
        oMaxValue <= max_nx;
        oPixCount <= pix_cnt;
      end
    end
  end

  always_ff @(posedge iClk) begin
    bin_p0 <= iGray;
    if (state == INIT_CLR) begin
      wr_addr_p1 <= cnt[7:0];
      wr_data_p1 <= '0;
    end else if (state == CUMSUM) begin
      wr_addr_p1 <= cnt_lo_m1;
      wr_data_p1 <= '0;
    end else begin
      wr_addr_p1 <= bin_p0;
      wr_data_p1 <= sat_inc(fwd_p0);
    end
    wr_addr_p2 <= wr_addr_p1;
    wr_data_p2 <= wr_data_p1;
    if (state == WAIT_SOF && rise) pix_cnt <= '0;
    else if (pix_ok)               pix_cnt <= sat_inc(pix_cnt);
    if (state == FLUSH) begin
      cum    <= '0;
      max_sh <= '0;
    end else if (cum_step) begin
      cum    <= cum_nx;
      max_sh <= max_nx;
    end
    if (cum_step && !f25 && cum_nx >= t25) th25_sh <= cnt_lo_m1;
    if (cum_step && !f50 && cum_nx >= t50) th50_sh <= cnt_lo_m1;
    if (cum_step && !f75 && cum_nx >= t75) th75_sh <= cnt_lo_m1;
  end

endmodule
